// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer: FSM encoding,
// tile pin indices and the majority helper used by the full-adder slice.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_ADD  = 2'b10,
        ST_OUT  = 2'b11
    } state_t;

    localparam int IN_CLK       = 0;
    localparam int IN_RST       = 1;
    localparam int IN_START     = 2;
    localparam int IN_A         = 3;
    localparam int IN_B         = 4;
    localparam int IN_VALID     = 5;
    localparam int IN_SUB       = 6;
    localparam int IN_OUT_READY = 7;

    localparam int OUT_SUM      = 0;
    localparam int OUT_VALID    = 1;
    localparam int OUT_BUSY     = 2;
    localparam int OUT_CARRY    = 3;
    localparam int OUT_OVF      = 4;
    localparam int OUT_STATE_LO = 5;
    localparam int OUT_STATE_HI = 6;
    localparam int OUT_IN_READY = 7;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/serial_fa_slice.sv
// One-bit full-adder slice with its carry flip-flop; B is inverted in subtract
// mode so that A-B is computed as A + ~B + 1 with the +1 preloaded as carry.
module serial_fa_slice
    import serial_adder_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic init,
    input  logic init_val,
    input  logic en,
    input  logic a,
    input  logic b,
    input  logic mode,
    output logic sum,
    output logic carry_in,
    output logic carry_next
);

    logic bx_s;
    logic carry_r;

    assign bx_s       = b ^ mode;
    assign sum        = a ^ bx_s ^ carry_r;
    assign carry_next = maj3(a, bx_s, carry_r);
    assign carry_in   = carry_r;

    // Carry register: preloaded just before the first add cycle, advanced while enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_r <= 1'b0;
        end else if (init) begin
            carry_r <= init_val;
        end else if (en) begin
            carry_r <= carry_next;
        end else begin
            carry_r <= carry_r;
        end
    end

endmodule

// File: rtl/serial_adder_sequencer.sv
// Bit-serial add/subtract sequencer on the 8-bit tile pins: serial operand load,
// WIDTH add cycles through one full-adder slice, then handshaked serial result.
module serial_adder_sequencer
    import serial_adder_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic clk_s, rst_s, start_s, a_in_s, b_in_s, in_valid_s, sub_s, out_ready_s;
    logic sum_s, carry_in_s, carry_next_s, load_last_s;

    state_t             state_r;
    logic [WIDTH-1:0]   a_r, b_r, r_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               mode_r, carry_out_r, overflow_r;

    assign clk_s       = io_in[IN_CLK];
    assign rst_s       = io_in[IN_RST];
    assign start_s     = io_in[IN_START];
    assign a_in_s      = io_in[IN_A];
    assign b_in_s      = io_in[IN_B];
    assign in_valid_s  = io_in[IN_VALID];
    assign sub_s       = io_in[IN_SUB];
    assign out_ready_s = io_in[IN_OUT_READY];

    assign load_last_s = (state_r == ST_LOAD) && in_valid_s && (cnt_r == LAST_CNT);

    serial_fa_slice u_slice (
        .clk        (clk_s),
        .rst        (rst_s),
        .init       (load_last_s),
        .init_val   (mode_r),
        .en         (state_r == ST_ADD),
        .a          (a_r[0]),
        .b          (b_r[0]),
        .mode       (mode_r),
        .sum        (sum_s),
        .carry_in   (carry_in_s),
        .carry_next (carry_next_s)
    );

    // Controller FSM with bit counter, operand/result shift registers and result flags.
    always_ff @(posedge clk_s or posedge rst_s) begin
        if (rst_s) begin
            state_r     <= ST_IDLE;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            r_r         <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            mode_r      <= 1'b0;
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r     <= ST_LOAD;
                        mode_r      <= sub_s;
                        cnt_r       <= {CNT_W{1'b0}};
                        carry_out_r <= 1'b0;
                        overflow_r  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (in_valid_s) begin
                        a_r <= {a_in_s, a_r[WIDTH-1:1]};
                        b_r <= {b_in_s, b_r[WIDTH-1:1]};
                        if (cnt_r == LAST_CNT) begin
                            cnt_r   <= {CNT_W{1'b0}};
                            state_r <= ST_ADD;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                ST_ADD: begin
                    a_r <= {1'b0, a_r[WIDTH-1:1]};
                    b_r <= {1'b0, b_r[WIDTH-1:1]};
                    r_r <= {sum_s, r_r[WIDTH-1:1]};
                    if (cnt_r == LAST_CNT) begin
                        // carry_in_s is the carry into the MSB on this final cycle.
                        cnt_r       <= {CNT_W{1'b0}};
                        carry_out_r <= carry_next_s;
                        overflow_r  <= carry_in_s ^ carry_next_s;
                        state_r     <= ST_OUT;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_OUT: begin
                    if (out_ready_s) begin
                        r_r <= {1'b0, r_r[WIDTH-1:1]};
                        if (cnt_r == LAST_CNT) begin
                            cnt_r   <= {CNT_W{1'b0}};
                            state_r <= ST_IDLE;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Pin map decoded purely from registered state.
    always_comb begin
        io_out               = 8'h00;
        io_out[OUT_SUM]      = (state_r == ST_OUT) & r_r[0];
        io_out[OUT_VALID]    = (state_r == ST_OUT);
        io_out[OUT_BUSY]     = (state_r != ST_IDLE);
        io_out[OUT_CARRY]    = carry_out_r;
        io_out[OUT_OVF]      = overflow_r;
        io_out[OUT_STATE_LO] = state_r[0];
        io_out[OUT_STATE_HI] = state_r[1];
        io_out[OUT_IN_READY] = (state_r == ST_LOAD);
    end

endmodule

// File: tb/tb_serial_adder_sequencer.sv
// Directed bench for serial_adder_sequencer: arithmetic reference model checked
// every cycle, plus literal expectations for each transaction.
module tb_serial_adder_sequencer;

    logic clk, rst, start, a_in, b_in, in_valid, sub, out_ready;
    logic [7:0] io_in, io_out;

    int n_cmp = 0;
    int n_fail = 0;

    assign io_in = {out_ready, sub, in_valid, b_in, a_in, start, rst, clk};

    serial_adder_sequencer #(.WIDTH(8)) dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] bop(input logic [7:0] b, input logic m);
        return m ? ~b : b;
    endfunction

    function automatic logic [8:0] full_sum(input logic [7:0] a, input logic [7:0] b, input logic m);
        return {1'b0, a} + {1'b0, bop(b, m)} + {8'd0, m};
    endfunction

    function automatic logic [7:0] res_fn(input logic [7:0] a, input logic [7:0] b, input logic m);
        logic [8:0] s;
        s = full_sum(a, b, m);
        return s[7:0];
    endfunction

    function automatic logic carry_fn(input logic [7:0] a, input logic [7:0] b, input logic m);
        logic [8:0] s;
        s = full_sum(a, b, m);
        return s[8];
    endfunction

    function automatic logic ovf_fn(input logic [7:0] a, input logic [7:0] b, input logic m);
        logic [7:0] r, bx;
        r  = res_fn(a, b, m);
        bx = bop(b, m);
        return (a[7] == bx[7]) && (r[7] != a[7]);
    endfunction

    // Reference model: phase, bit position, collected operands, arithmetic result.
    int         m_phase, m_cnt;
    logic [7:0] m_a, m_b, m_res;
    logic       m_mode, m_carry, m_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0; m_cnt <= 0; m_a <= 8'h00; m_b <= 8'h00; m_res <= 8'h00;
            m_mode <= 1'b0; m_carry <= 1'b0; m_ovf <= 1'b0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase <= 1; m_mode <= sub; m_cnt <= 0;
                    m_a <= 8'h00; m_b <= 8'h00; m_carry <= 1'b0; m_ovf <= 1'b0;
                end
                1: if (in_valid) begin
                    m_a[m_cnt] <= a_in;
                    m_b[m_cnt] <= b_in;
                    if (m_cnt == 7) begin m_phase <= 2; m_cnt <= 0; end
                    else m_cnt <= m_cnt + 1;
                end
                2: if (m_cnt == 7) begin
                    m_phase <= 3; m_cnt <= 0;
                    m_res   <= res_fn(m_a, m_b, m_mode);
                    m_carry <= carry_fn(m_a, m_b, m_mode);
                    m_ovf   <= ovf_fn(m_a, m_b, m_mode);
                end else m_cnt <= m_cnt + 1;
                3: if (out_ready) begin
                    if (m_cnt == 7) begin m_phase <= 0; m_cnt <= 0; end
                    else m_cnt <= m_cnt + 1;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    // Per-cycle compare against the model, plus capture of handshaked result bits.
    logic [7:0] exp_v;
    logic [7:0] got_word;
    int         got_cnt = 0;
    logic [1:0] ph2;

    initial begin
        forever begin
            @(negedge clk);
            ph2 = m_phase[1:0];
            exp_v = 8'h00;
            exp_v[0] = (m_phase == 3) ? m_res[m_cnt] : 1'b0;
            exp_v[1] = (m_phase == 3);
            exp_v[2] = (m_phase != 0);
            exp_v[3] = m_carry;
            exp_v[4] = m_ovf;
            exp_v[6:5] = ph2;
            exp_v[7] = (m_phase == 1);
            n_cmp++;
            if (io_out !== exp_v) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t io_out=%b expected=%b", $time, io_out, exp_v);
            end
            if (m_phase == 1) got_cnt = 0;
            if (io_out[1] && out_ready && got_cnt < 8) begin
                got_word[got_cnt] = io_out[0];
                got_cnt++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // One transaction; gaps toggles in_valid, stall holds out_ready low 5 cycles,
    // noise pulses start/toggles sub while busy, rst_at>0 resets after that many edges.
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic s,
                           input bit gaps, input bit stall, input bit noise,
                           input int rst_at, output int ncyc);
        int  bi, cyc, stall_left;
        bit  acc_in;
        @(negedge clk); #1;
        start = 1'b1; sub = s; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        bi = 0; cyc = 0; stall_left = 0;
        while (io_out[2] && cyc < 100) begin
            if (rst_at != 0 && cyc == rst_at) begin
                check("state_before_reset", {30'd0, io_out[6:5]}, 32'd2);
                rst = 1'b1;
                #1;
                check("reset_mid_add_out", {24'd0, io_out}, 32'd0);
                in_valid = 1'b0;
                @(negedge clk); #1;
                rst = 1'b0;
                break;
            end
            if (io_out[7]) begin
                in_valid = (gaps && cyc % 2 == 1) ? 1'b0 : 1'b1;
                a_in = a[bi[2:0]];
                b_in = b[bi[2:0]];
            end else begin
                in_valid = 1'b0;
                a_in = cyc[0];
                b_in = cyc[1];
            end
            if (noise) begin
                sub = cyc[0];
                start = (cyc % 3 == 0);
            end
            if (stall && io_out[1] && got_cnt == 3 && stall_left < 5) begin
                out_ready = 1'b0;
                stall_left++;
            end else begin
                out_ready = 1'b1;
            end
            acc_in = in_valid && io_out[7];
            @(negedge clk); #1;
            if (acc_in) bi++;
            cyc++;
        end
        if (rst_at == 0) check("txn_terminates", {31'd0, io_out[2]}, 32'd0);
        start = 1'b0; in_valid = 1'b0; sub = 1'b0; out_ready = 1'b1;
        ncyc = cyc;
    endtask

    task automatic expect_result(input string name, input logic [7:0] r, input logic c, input logic o);
        check({name, "_result"}, {24'd0, got_word}, {24'd0, r});
        check({name, "_bits"}, got_cnt, 32'd8);
        check({name, "_carry"}, {31'd0, io_out[3]}, {31'd0, c});
        check({name, "_ovf"}, {31'd0, io_out[4]}, {31'd0, o});
    endtask

    initial begin
        int ncyc;
        rst = 1'b1; start = 1'b0; a_in = 1'b0; b_in = 1'b0;
        in_valid = 1'b0; sub = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {24'd0, io_out}, 32'd0);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        run_txn(8'h5A, 8'h3C, 1'b0, 0, 0, 0, 0, ncyc);
        expect_result("add_5a_3c", 8'h96, 1'b0, 1'b1);
        check("add_latency_edges", ncyc, 32'd24);
        repeat (3) @(negedge clk);
        check("flags_held_idle", {30'd0, io_out[4:3]}, 32'd2);

        run_txn(8'hFF, 8'h01, 1'b0, 0, 0, 0, 0, ncyc);
        expect_result("wrap_ff_01", 8'h00, 1'b1, 1'b0);

        run_txn(8'h10, 8'h20, 1'b1, 0, 0, 0, 0, ncyc);
        expect_result("sub_10_20", 8'hF0, 1'b0, 1'b0);

        run_txn(8'h80, 8'h01, 1'b1, 0, 0, 0, 0, ncyc);
        expect_result("sub_80_01", 8'h7F, 1'b1, 1'b1);

        run_txn(8'hC3, 8'h5A, 1'b0, 1, 1, 0, 0, ncyc);
        expect_result("flow_c3_5a", 8'h1D, 1'b1, 1'b0);
        check("flow_latency_longer", {31'd0, ncyc > 24 + 4}, 32'd1);

        run_txn(8'hA5, 8'h0F, 1'b0, 0, 0, 0, 10, ncyc);
        repeat (2) @(negedge clk);
        run_txn(8'h01, 8'h02, 1'b0, 0, 0, 0, 0, ncyc);
        expect_result("after_reset_01_02", 8'h03, 1'b0, 1'b0);

        run_txn(8'h37, 8'h4C, 1'b1, 0, 0, 1, 0, ncyc);
        expect_result("noise_sub_37_4c", 8'hEB, 1'b0, 1'b0);
        check("noise_latency", ncyc, 32'd24);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
